dense_seq_ctrl: RTL and testbench

DENSE_SEQ_CTRL -- requirements
Module: dense_seq_ctrl

---
 rtl/dense_seq_ctrl_pkg.sv | 15 +
 rtl/dense_seq_ctrl.sv | 113 +++++++++++
 tb/tb_dense_seq_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dense_seq_ctrl_pkg.sv
// Shared constants and FSM state type for the dense-layer input sequencer.
package dense_pkg;

  localparam int IN_W_DEF    = 128;
  localparam int CHUNK_W_DEF = 2;
  localparam int NUM_CYC_DEF = 512;
  localparam int CHUNKS      = IN_W_DEF / CHUNK_W_DEF;
  localparam int ADDR_W      = $clog2(NUM_CYC_DEF);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/dense_seq_ctrl.sv
// Double-buffered vector sequencer: HOLD -> SHIFT, issues CHUNK_W bits per cycle MSB-first
// with the weight-ROM address leading the data by one cycle.
//   state  | meaning
//   IDLE   | SHIFT empty, nothing issuing; w_addr holds
//   STREAM | SHIFT valid, one chunk on data_vec every cycle
module dense_seq_ctrl
  import dense_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int CHUNK_W = CHUNK_W_DEF,
  parameter int NUM_CYC = NUM_CYC_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       vld_in,
  output logic                       rdy_in,
  input  logic [IN_W-1:0]            data_in,
  output logic [$clog2(NUM_CYC)-1:0] w_addr,
  output logic                       vld_out,
  output logic [CHUNK_W-1:0]         data_vec,
  output logic                       seg_first,
  output logic                       seg_last,
  output logic                       frame_done
);

  localparam int NCHUNK = IN_W / CHUNK_W;
  localparam int AW     = $clog2(NUM_CYC);
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t            state, state_nxt;
  logic              hold_full;
  logic [IN_W-1:0]   hold_data;
  logic [IN_W-1:0]   shift_data;
  logic [CNT_W-1:0]  cnt;
  logic              streaming, last, load_now, accept, bypass, issue_addr;

  always_comb begin
    streaming  = (state == STREAM);
    last       = streaming && (cnt == CNT_W'(NCHUNK - 1));
    load_now   = hold_full && (!streaming || last) && !flush;
    rdy_in     = rst && !flush && (!hold_full || load_now);
    accept     = vld_in && rdy_in;
    // A vector arriving on the last chunk with HOLD empty goes straight to SHIFT so the stream never bubbles.
    bypass     = last && !hold_full && accept;
    issue_addr = load_now || bypass || (streaming && !last);
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (load_now) state_nxt = STREAM;
        STREAM:  if (last && !(load_now || bypass)) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_full  <= 1'b0;
      hold_data  <= '0;
      shift_data <= '0;
      cnt        <= '0;
      w_addr     <= '0;
    end else if (flush) begin
      hold_full <= 1'b0;
      cnt       <= '0;
      w_addr    <= '0;
    end else begin
      if (accept && !bypass) begin
        hold_full <= 1'b1;
        hold_data <= data_in;
      end else if (load_now) begin
        hold_full <= 1'b0;
      end

      if (load_now) begin
        shift_data <= hold_data;
        cnt        <= '0;
      end else if (bypass) begin
        shift_data <= data_in;
        cnt        <= '0;
      end else if (last) begin
        cnt <= '0;
      end else if (streaming) begin
        shift_data <= shift_data << CHUNK_W;
        cnt        <= cnt + 1'b1;
      end

      if (issue_addr)
        w_addr <= (w_addr == AW'(NUM_CYC - 1)) ? '0 : w_addr + 1'b1;
    end
  end

  // w_addr already points one past the chunk on data_vec, so it reads 0 right after address NUM_CYC-1.
  always_comb begin
    vld_out    = streaming;
    data_vec   = streaming ? shift_data[IN_W-1 -: CHUNK_W] : '0;
    seg_first  = streaming && (cnt == '0);
    seg_last   = last;
    frame_done = streaming && (w_addr == '0);
  end

endmodule

// File: tb/tb_dense_seq_ctrl.sv
// Scoreboard bench for dense_seq_ctrl: accepted vectors are expanded into expected chunks and checked as they issue.
module tb_dense_seq_ctrl;

  localparam int IN_W = 128;
  localparam int NCH  = 64;
  localparam int NCYC = 512;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            flush = 1'b0;
  logic            vld_in = 1'b0;
  logic            rdy_in;
  logic [IN_W-1:0] data_in = '0;
  logic [8:0]      w_addr;
  logic            vld_out;
  logic [1:0]      data_vec;
  logic            seg_first, seg_last, frame_done;

  dense_seq_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .vld_in(vld_in), .rdy_in(rdy_in),
    .data_in(data_in), .w_addr(w_addr), .vld_out(vld_out), .data_vec(data_vec),
    .seg_first(seg_first), .seg_last(seg_last), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] d;
    logic       f;
    logic       l;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         exp_addr = 0;
  logic [8:0] prev_w_addr = '0;
  int         cyc = 0;
  int         n_tests = 0, n_fail = 0;
  int         vld_cnt = 0, fd_cnt = 0, first_vld_cyc = 0, last_vld_cyc = 0, seg_last_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic push_vec(input logic [IN_W-1:0] v);
    exp_t x;
    for (int k = 0; k < NCH; k++) begin
      x.d = v[IN_W-1 -: 2];
      x.f = (k == 0);
      x.l = (k == NCH - 1);
      v   = v << 2;
      sb.push_back(x);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      exp_addr = 0;
    end else begin
      n_tests++;
      if (vld_out) begin
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: vld_out=1 data_vec=%0d at cycle %0d, nothing expected", data_vec, cyc);
        end else begin
          e = sb.pop_front();
          if (data_vec !== e.d || seg_first !== e.f || seg_last !== e.l ||
              prev_w_addr !== exp_addr[8:0] || frame_done !== (exp_addr == NYC_LAST())) begin
            n_fail++;
            $display("FAIL sb_chunk cyc %0d: got d=%0d f=%0b l=%0b addr=%0d fd=%0b, want d=%0d f=%0b l=%0b addr=%0d fd=%0b",
                     cyc, data_vec, seg_first, seg_last, prev_w_addr, frame_done,
                     e.d, e.f, e.l, exp_addr, (exp_addr == NYC_LAST()));
          end
          exp_addr = (exp_addr + 1) % NCYC;
        end
        vld_cnt++;
        if (vld_cnt == 1) first_vld_cyc = cyc;
        last_vld_cyc = cyc;
        if (seg_last) seg_last_cyc = cyc;
        if (frame_done) fd_cnt++;
      end else if (data_vec !== 2'd0 || frame_done !== 1'b0 || seg_first !== 1'b0 || seg_last !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_outputs cyc %0d: data_vec=%0d fd=%0b sf=%0b sl=%0b, want all 0",
                 cyc, data_vec, frame_done, seg_first, seg_last);
      end
      if (flush) begin
        sb.delete();
        exp_addr = 0;
      end else if (vld_in && rdy_in) begin
        push_vec(data_in);
      end
    end
    prev_w_addr = w_addr;
  end

  function automatic int NYC_LAST();
    return NCYC - 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IN_W-1:0] v, output int t);
    bit got = 0;
    vld_in  = 1'b1;
    data_in = v;
    t = 0;
    for (int w = 0; w < 300 && !got; w++) begin
      @(negedge clk);
      if (rdy_in) begin
        got = 1;
        t = cyc;
      end
      tick();
    end
    vld_in = 1'b0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: rdy_in never high, want accept within 300 cycles");
    end
  endtask

  task automatic wait_first_vld(output int f);
    bit got = 0;
    f = 0;
    for (int w = 0; w < 10 && !got; w++) begin
      @(negedge clk);
      if (vld_out) begin
        got = 1;
        f = cyc;
      end
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL vld_timeout: vld_out stayed 0, want 1 within 10 cycles");
    end
  endtask

  task automatic wait_idle();
    bit got = 0;
    for (int w = 0; w < 800 && !got; w++) begin
      @(negedge clk);
      if (!vld_out && sb.size() == 0) got = 1;
    end
    tick();
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: vld_out=%0b pending=%0d, want idle", vld_out, sb.size());
    end
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if (rdy_in !== 1'b0) begin
      n_fail++; $display("FAIL reset_rdy: rdy_in=%0b, want 0", rdy_in);
    end
    n_tests++;
    if (vld_out !== 0 || data_vec !== 0 || w_addr !== 0 || seg_first !== 0 || seg_last !== 0 || frame_done !== 0) begin
      n_fail++;
      $display("FAIL reset_outputs: vld=%0b d=%0d addr=%0d sf=%0b sl=%0b fd=%0b, want all 0",
               vld_out, data_vec, w_addr, seg_first, seg_last, frame_done);
    end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (rdy_in !== 1'b1 || w_addr !== 9'd0) begin
      n_fail++; $display("FAIL release_rdy: rdy_in=%0b w_addr=%0d, want 1 and 0", rdy_in, w_addr);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int  acc[9];
    bit  got;
    vld_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      vld_in  = 1'b1;
      data_in = {$urandom, $urandom, $urandom, $urandom};
      got = 0;
      for (int w = 0; w < 200 && !got; w++) begin
        @(negedge clk);
        if (rdy_in) begin
          acc[i] = cyc;
          got = 1;
        end
        tick();
      end
      if (!got) begin
        acc[i] = -1000;
        n_tests++; n_fail++;
        $display("FAIL b2b_accept_timeout: vector %0d never accepted", i);
      end
    end
    vld_in = 1'b0;
    for (int i = 1; i < 9; i++) begin
      n_tests++;
      if (acc[i] - acc[0] !== 1 + NCH * (i - 1)) begin
        n_fail++;
        $display("FAIL b2b_accept_time: vector %0d accepted at +%0d, want +%0d", i, acc[i] - acc[0], 1 + NCH * (i - 1));
      end
    end
    wait_idle();
    n_tests++;
    if (vld_cnt !== 9 * NCH || last_vld_cyc - first_vld_cyc !== 9 * NCH - 1 || first_vld_cyc !== acc[0] + 2) begin
      n_fail++;
      $display("FAIL b2b_contiguous: cnt=%0d span=%0d first=+%0d, want %0d, %0d, +2",
               vld_cnt, last_vld_cyc - first_vld_cyc, first_vld_cyc - acc[0], 9 * NCH, 9 * NCH - 1);
    end
    n_tests++;
    if (fd_cnt !== 1) begin
      n_fail++; $display("FAIL b2b_frame_done: pulses=%0d, want 1", fd_cnt);
    end
  endtask

  task automatic test_single();
    int t;
    vld_cnt = 0;
    send({2'b11, 124'd0, 2'b11}, t);
    wait_idle();
    n_tests++;
    if (first_vld_cyc !== t + 2 || seg_last_cyc !== t + 65 || vld_cnt !== NCH) begin
      n_fail++;
      $display("FAIL single_timing: first=+%0d last=+%0d cnt=%0d, want +2 +65 64",
               first_vld_cyc - t, seg_last_cyc - t, vld_cnt);
    end
  endtask

  task automatic test_zero_bubble();
    int t, f;
    vld_cnt = 0;
    send({$urandom, $urandom, $urandom, $urandom}, t);
    wait_first_vld(f);
    repeat (NCH - 1) tick();
    vld_in  = 1'b1;
    data_in = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    n_tests++;
    if (seg_last !== 1'b1 || rdy_in !== 1'b1) begin
      n_fail++; $display("FAIL zb_last_accept: seg_last=%0b rdy_in=%0b, want 1 1", seg_last, rdy_in);
    end
    tick();
    vld_in = 1'b0;
    wait_idle();
    n_tests++;
    if (vld_cnt !== 2 * NCH || last_vld_cyc - first_vld_cyc !== 2 * NCH - 1) begin
      n_fail++;
      $display("FAIL zb_contiguous: cnt=%0d span=%0d, want %0d %0d", vld_cnt, last_vld_cyc - first_vld_cyc, 2 * NCH, 2 * NCH - 1);
    end
  endtask

  task automatic test_flush();
    int t, f;
    send({$urandom, $urandom, $urandom, $urandom}, t);
    send({$urandom, $urandom, $urandom, $urandom}, t);
    wait_first_vld(f);
    repeat (30) tick();
    flush   = 1'b1;
    vld_in  = 1'b1;
    data_in = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    n_tests++;
    if (rdy_in !== 1'b0) begin
      n_fail++; $display("FAIL flush_rdy: rdy_in=%0b, want 0", rdy_in);
    end
    tick();
    flush  = 1'b0;
    vld_in = 1'b0;
    @(negedge clk);
    n_tests++;
    if (vld_out !== 1'b0 || w_addr !== 9'd0) begin
      n_fail++; $display("FAIL flush_clear: vld_out=%0b w_addr=%0d, want 0 0", vld_out, w_addr);
    end
    tick();
    vld_cnt = 0;
    send({$urandom, $urandom, $urandom, $urandom}, t);
    wait_idle();
    n_tests++;
    if (vld_cnt !== NCH || first_vld_cyc !== t + 2) begin
      n_fail++; $display("FAIL flush_next: cnt=%0d first=+%0d, want 64 +2", vld_cnt, first_vld_cyc - t);
    end
  endtask

  task automatic test_async_reset();
    int t, f;
    send({$urandom, $urandom, $urandom, $urandom}, t);
    wait_first_vld(f);
    repeat (10) tick();
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (rdy_in !== 0 || vld_out !== 0 || data_vec !== 0 || w_addr !== 0 ||
        seg_first !== 0 || seg_last !== 0 || frame_done !== 0) begin
      n_fail++;
      $display("FAIL async_reset: rdy=%0b vld=%0b d=%0d addr=%0d sf=%0b sl=%0b fd=%0b, want all 0",
               rdy_in, vld_out, data_vec, w_addr, seg_first, seg_last, frame_done);
    end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (rdy_in !== 1'b1) begin
      n_fail++; $display("FAIL async_release_rdy: rdy_in=%0b, want 1", rdy_in);
    end
    tick();
    vld_cnt = 0;
    send({$urandom, $urandom, $urandom, $urandom}, t);
    wait_idle();
    n_tests++;
    if (vld_cnt !== NCH) begin
      n_fail++; $display("FAIL async_next: cnt=%0d, want 64", vld_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_zero_bubble();
    test_flush();
    test_async_reset();
    n_tests++;
    if (sb.size() !== 0) begin
      n_fail++; $display("FAIL sb_drain: %0d chunks pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
